note_playback: RTL and testbench

Playback reader for the piano's recorded-note buffer. On a start pulse it fetches the stored notes in order over a request/acknowledge read port, then presents each one on the note output for a fixed number of tempo ticks. Recording writes the buffer; this block reads it back. It sits between the buffer and the tone generator and is active only while the piano is in playback mode.

---
 rtl/note_playback.sv | 126 ++++++++++++
 tb/tb_note_playback.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_playback.sv
// rtl/note_playback.sv - playback reader: fetches recorded notes in order and holds each for a fixed tick count
module note_playback #(
    parameter int NOTE_W         = 6,
    parameter int ADDR_W         = 5,
    parameter int TICKS_PER_NOTE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              tick,
    input  logic [ADDR_W:0]   note_count,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [NOTE_W-1:0] rd_data,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_on,
    output logic              busy,
    output logic              done
);

    localparam int TW = $clog2(TICKS_PER_NOTE + 1);
    localparam logic [TW-1:0]     TICK_ONE  = 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICKS_PER_NOTE);
    localparam logic [ADDR_W-1:0] IDX_ONE   = 1;
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;

    typedef enum logic [2:0] {IDLE, FETCH, HOLD, NEXT, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic              load;
    logic              last;
    logic              rd_req_d, busy_d, done_d, note_on_d;
    logic [NOTE_W-1:0] note_out_d;

    assign last    = ({1'b0, idx_q} == cnt_q - CNT_ONE);
    assign rd_addr = idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            tick_q   <= '0;
            rd_req   <= 1'b0;
            note_out <= '0;
            note_on  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            rd_req   <= rd_req_d;
            note_out <= note_out_d;
            note_on  <= note_on_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tick_d  = tick_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    cnt_d   = note_count;
                    idx_d   = '0;
                    // an empty buffer passes through NEXT so done lands two cycles after start
                    state_d = (note_count == '0) ? NEXT : FETCH;
                end
            end
            FETCH: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (rd_ack) begin
                    load    = 1'b1;
                    tick_d  = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    tick_d = tick_q + TICK_ONE;
                    if (tick_d == TICK_LAST) state_d = NEXT;
                end
            end
            NEXT: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == '0 || (last && !loop)) begin
                    state_d = DONE;
                end else if (last) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_req_d   = (state_d == FETCH);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        note_out_d = load ? rd_data : note_out;
        note_on_d  = (state_d == HOLD) && (load ? (rd_data != '0) : note_on);
    end

endmodule

// File: tb/tb_note_playback.sv
// tb/tb_note_playback.sv - directed self-checking bench for note_playback
module tb_note_playback;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, loop, tick;
    logic [5:0] note_count;
    logic       rd_req;
    logic [4:0] rd_addr;
    logic       rd_ack;
    logic [5:0] rd_data;
    logic [5:0] note_out;
    logic       note_on, busy, done;

    logic       resp_ack, force_ack;
    logic [5:0] resp_data;
    logic [5:0] mem [32];
    int         ack_delay, tick_period, resp_en, tick_en;
    int         wait_cnt, tcnt, hold_ticks, done_cnt, req_cycles;
    int         clr_gen, clr_seen;
    bit         in_note, ack_prev, addr_unstable;
    logic [4:0] wait_addr;
    logic [4:0] addr_q [$];
    logic [6:0] note_q [$];
    int         ticks_q [$];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    assign rd_ack  = resp_ack | force_ack;
    assign rd_data = force_ack ? 6'd33 : resp_data;

    note_playback dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .tick(tick), .note_count(note_count), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .note_out(note_out), .note_on(note_on),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Tick generator, buffer responder and observation log, all on the falling edge.
    always @(negedge clk) begin
        if (clr_seen != clr_gen) begin
            clr_seen = clr_gen;
            addr_q.delete(); note_q.delete(); ticks_q.delete();
            done_cnt = 0; req_cycles = 0; addr_unstable = 0;
        end
        if (!rst_n) begin
            tick = 0; tcnt = 0; resp_ack = 0; wait_cnt = 0; in_note = 0; ack_prev = 0;
        end else begin
            if (tick_en != 0) begin
                tcnt++;
                tick = (tcnt % tick_period == 0);
            end else tick = 0;
            if (ack_prev) begin
                note_q.push_back({note_out, note_on});
                ack_prev = 0;
            end
            if (in_note) begin
                if (rd_req || done || !busy) begin
                    ticks_q.push_back(hold_ticks);
                    in_note = 0;
                end else if (tick) hold_ticks++;
            end
            if (done) done_cnt++;
            if (rd_req) req_cycles++;
            resp_ack = 0;
            if (rd_req && resp_en != 0) begin
                if (wait_cnt > 0 && rd_addr != wait_addr) addr_unstable = 1;
                wait_addr = rd_addr;
                if (wait_cnt >= ack_delay) begin
                    resp_ack = 1; resp_data = mem[rd_addr];
                    addr_q.push_back(rd_addr);
                    ack_prev = 1; in_note = 1; hold_ticks = 0; wait_cnt = 0;
                end else wait_cnt++;
            end else wait_cnt = 0;
        end
    end

    task automatic clear_log();
        clr_gen++;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; stop = 0; loop = 0; note_count = 0; force_ack = 0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({rd_req, rd_addr, note_out, note_on, busy, done} !== 15'd0) $display("FAIL reset_outputs got %h want 0", {rd_req, rd_addr, note_out, note_on, busy, done});
        else pass_cnt++;
        rst_n = 1;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || rd_req !== 1'b0) $display("FAIL reset_release busy=%b rd_req=%b want 0,0", busy, rd_req);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        bit ok;
        mem[0] = 6'd12; mem[1] = 6'd0; mem[2] = 6'd7;
        note_count = 6'd3; ack_delay = 1; tick_period = 4; loop = 0;
        clear_log();
        pulse_start();
        total_cnt++;
        if (busy !== 1'b1 || rd_req !== 1'b1 || rd_addr !== 5'd0) $display("FAIL basic_first_cycle busy=%b rd_req=%b addr=%0d want 1,1,0", busy, rd_req, rd_addr);
        else pass_cnt++;
        wait_idle(300, ok);
        total_cnt++;
        if (!ok) $display("FAIL basic_timeout busy=%b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (addr_q.size() != 3 || addr_q[0] !== 5'd0 || addr_q[1] !== 5'd1 || addr_q[2] !== 5'd2) $display("FAIL basic_addrs got %p want 0,1,2", addr_q);
        else pass_cnt++;
        total_cnt++;
        if (note_q.size() != 3 || note_q[0] !== {6'd12, 1'b1} || note_q[1] !== {6'd0, 1'b0} || note_q[2] !== {6'd7, 1'b1}) $display("FAIL basic_notes got %p want {12,1},{0,0},{7,1}", note_q);
        else pass_cnt++;
        total_cnt++;
        if (ticks_q.size() != 3 || ticks_q[0] != 2 || ticks_q[1] != 2 || ticks_q[2] != 2) $display("FAIL basic_hold_ticks got %p want 2,2,2", ticks_q);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1) $display("FAIL basic_done_pulses got %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++;
        if (note_out !== 6'd7 || note_on !== 1'b0) $display("FAIL basic_final_note got %0d/%b want 7/0", note_out, note_on);
        else pass_cnt++;
    endtask

    task automatic test_slow_buffer();
        bit ok;
        mem[0] = 6'd9; note_count = 6'd1; ack_delay = 5; tick_period = 4;
        clear_log();
        pulse_start();
        wait_idle(300, ok);
        total_cnt++;
        if (!ok) $display("FAIL slow_timeout busy=%b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (req_cycles != 6 || addr_unstable) $display("FAIL slow_req_steady cycles=%0d unstable=%b want 6,0", req_cycles, addr_unstable);
        else pass_cnt++;
        total_cnt++;
        if (ticks_q.size() != 1 || ticks_q[0] != 2) $display("FAIL slow_hold_ticks got %p want 2", ticks_q); else pass_cnt++;
        total_cnt++;
        if (note_q.size() != 1 || note_q[0] !== {6'd9, 1'b1}) $display("FAIL slow_note got %p want {9,1}", note_q); else pass_cnt++;
    endtask

    task automatic test_loop();
        bit ok;
        mem[0] = 6'd3; mem[1] = 6'd4; note_count = 6'd2; ack_delay = 0; loop = 1;
        clear_log();
        pulse_start();
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (addr_q.size() >= 3) begin ok = 1; break; end
        end
        total_cnt++;
        if (!ok || done_cnt != 0) $display("FAIL loop_second_pass reached=%b done=%0d want 1,0", ok, done_cnt); else pass_cnt++;
        loop = 0;
        wait_idle(300, ok);
        total_cnt++;
        if (!ok || done_cnt != 1) $display("FAIL loop_exit idle=%b done=%0d want 1,1", ok, done_cnt); else pass_cnt++;
        total_cnt++;
        if (addr_q.size() != 4 || addr_q[0] !== 5'd0 || addr_q[1] !== 5'd1 || addr_q[2] !== 5'd0 || addr_q[3] !== 5'd1) $display("FAIL loop_addrs got %p want 0,1,0,1", addr_q);
        else pass_cnt++;
    endtask

    task automatic test_stop_fetch();
        logic [5:0] prev;
        note_count = 6'd4; resp_en = 0;
        clear_log();
        pulse_start();
        prev = note_out;
        repeat (2) @(negedge clk);
        stop = 1;
        @(negedge clk); stop = 0;
        total_cnt++;
        if (rd_req !== 1'b0 || busy !== 1'b0) $display("FAIL stop_fetch rd_req=%b busy=%b want 0,0", rd_req, busy); else pass_cnt++;
        force_ack = 1;
        @(negedge clk); force_ack = 0;
        @(negedge clk);
        total_cnt++;
        if (note_out !== prev || note_on !== 1'b0 || busy !== 1'b0 || done_cnt != 0) $display("FAIL stop_late_ack note=%0d on=%b busy=%b done=%0d want %0d,0,0,0", note_out, note_on, busy, done_cnt, prev);
        else pass_cnt++;
        resp_en = 1;
    endtask

    task automatic test_start_stop_same();
        @(negedge clk); start = 1; stop = 1;
        @(negedge clk); start = 0; stop = 0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || rd_req !== 1'b0) $display("FAIL start_stop_same busy=%b rd_req=%b want 0,0", busy, rd_req); else pass_cnt++;
    endtask

    task automatic test_start_busy();
        bit ok;
        mem[0] = 6'd5; note_count = 6'd1; ack_delay = 0;
        clear_log();
        pulse_start();
        note_count = 6'd3;
        for (int i = 0; i < 20 && note_on !== 1'b1; i++) @(negedge clk);
        pulse_start();
        wait_idle(300, ok);
        total_cnt++;
        if (!ok || done_cnt != 1 || addr_q.size() != 1) $display("FAIL start_busy idle=%b done=%0d fetches=%0d want 1,1,1", ok, done_cnt, addr_q.size());
        else pass_cnt++;
    endtask

    task automatic test_zero();
        note_count = 6'd0;
        clear_log();
        pulse_start();
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL zero_cycle1 busy=%b done=%b want 1,0", busy, done); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b1) $display("FAIL zero_cycle2_done got %b want 1", done); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || req_cycles != 0) $display("FAIL zero_cycle3 busy=%b done=%b reqs=%0d want 0,0,0", busy, done, req_cycles);
        else pass_cnt++;
    endtask

    task automatic test_full();
        bit ok;
        int bad;
        for (int i = 0; i < 32; i++) mem[i] = 6'(i + 1);
        note_count = 6'd32; ack_delay = 0; tick_period = 1;
        clear_log();
        pulse_start();
        wait_idle(1000, ok);
        bad = 0;
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== 5'(i)) bad++;
        total_cnt++;
        if (!ok || addr_q.size() != 32 || bad != 0) $display("FAIL full_addrs idle=%b count=%0d bad=%0d want 1,32,0", ok, addr_q.size(), bad);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1 || note_out !== 6'd32) $display("FAIL full_done done=%0d note=%0d want 1,32", done_cnt, note_out); else pass_cnt++;
    endtask

    task automatic test_reset_mid_hold();
        mem[0] = 6'd20; note_count = 6'd1; ack_delay = 0; tick_period = 4;
        clear_log();
        pulse_start();
        for (int i = 0; i < 20 && note_on !== 1'b1; i++) @(negedge clk);
        total_cnt++;
        if (note_on !== 1'b1) $display("FAIL midhold_reach note_on=%b want 1", note_on); else pass_cnt++;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        total_cnt++;
        if ({rd_req, note_out, note_on, busy, done} !== 10'd0) $display("FAIL midhold_async got %h want 0", {rd_req, note_out, note_on, busy, done});
        else pass_cnt++;
        @(negedge clk); rst_n = 1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || rd_req !== 1'b0 || rd_addr !== 5'd0) $display("FAIL midhold_release busy=%b rd_req=%b addr=%0d want 0,0,0", busy, rd_req, rd_addr);
        else pass_cnt++;
    endtask

    initial begin
        ack_delay = 1; tick_period = 4; resp_en = 1; tick_en = 1;
        clr_gen = 0; clr_seen = 0; resp_data = 0;
        test_reset();
        test_basic();
        test_slow_buffer();
        test_loop();
        test_stop_fetch();
        test_start_stop_same();
        test_start_busy();
        test_zero();
        test_full();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
